// File: rtl/serial_tx_queue_pkg.sv
// Shared UART transmit definitions: frame state encoding, default bit timing
// and MCU cclk readiness threshold.
package serial_tx_queue_pkg;

   localparam int DEFAULT_CLK_PER_BIT       = 100;
   localparam int DEFAULT_CCLK_READY_CYCLES = 512;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/serial_tx_queue_sync_fifo.sv
// Count-tracked synchronous FIFO with fall-through read data; a push against a
// full queue is accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/serial_tx_queue.sv
// Queued UART transmitter toward the AVR, gated by cclk readiness and tx_block.
// Define SERIAL_TX_PARITY_EN for an even-parity bit (8E1); default frame is 8N1.
module serial_tx_queue
   import serial_tx_queue_pkg::*;
#(
   parameter int CLK_PER_BIT       = DEFAULT_CLK_PER_BIT,
   parameter int FIFO_DEPTH        = 8,
   parameter int CCLK_READY_CYCLES = DEFAULT_CCLK_READY_CYCLES
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cclk,
   input  logic [7:0]                    tx_data,
   input  logic                          new_tx_data,
   input  logic                          tx_block,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int RW = $clog2(CCLK_READY_CYCLES + 1);
   localparam int BW = $clog2(CLK_PER_BIT + 1);

   tx_state_t     state_reg, state_next;
   logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
   logic [2:0]    bit_idx_reg, bit_idx_next;
   logic [7:0]    shift_reg, shift_next;
   logic          tx_reg, tx_next;
   logic          new_reg;
   logic          overflow_reg;
   logic [RW-1:0] ready_cnt_reg;
   logic          ready;
   logic          push;
   logic          pop;
   logic          bit_end;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;

   assign push    = new_tx_data && !new_reg;
   assign ready   = (ready_cnt_reg == RW'(CCLK_READY_CYCLES));
   assign bit_end = (bit_cnt_reg == BW'(CLK_PER_BIT - 1));

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (tx_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         new_reg       <= 1'b0;
         overflow_reg  <= 1'b0;
         ready_cnt_reg <= '0;
      end else begin
         new_reg <= new_tx_data;
         if (push && fifo_full && !pop) overflow_reg <= 1'b1;
         if (!cclk)       ready_cnt_reg <= '0;
         else if (!ready) ready_cnt_reg <= ready_cnt_reg + RW'(1);
      end
   end

`ifdef SERIAL_TX_PARITY_EN
   logic parity_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      parity_reg <= 1'b0;
      else if (pop) parity_reg <= even_parity(fifo_dout);
   end
`endif

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = '0;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      tx_next      = 1'b1;
      pop          = 1'b0;
      if (state_reg != ST_IDLE) bit_cnt_next = bit_end ? '0 : bit_cnt_reg + BW'(1);
      // tx is registered from the current state, so the line trails the FSM by one cycle
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty && ready && !tx_block) begin
               pop          = 1'b1;
               shift_next   = fifo_dout;
               bit_idx_next = 3'd0;
               state_next   = ST_START;
            end
         end
         ST_START: begin
            tx_next = 1'b0;
            if (bit_end) state_next = ST_DATA;
         end
         ST_DATA: begin
            tx_next = shift_reg[0];
            if (bit_end) begin
               shift_next   = {1'b0, shift_reg[7:1]};
               bit_idx_next = bit_idx_reg + 3'd1;
               if (bit_idx_reg == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_next = ST_PARITY;
`else
                  state_next = ST_STOP;
`endif
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         ST_PARITY: begin
            tx_next = parity_reg;
            if (bit_end) state_next = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bit_end) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         bit_cnt_reg <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         tx_reg      <= 1'b1;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
         tx_reg      <= tx_next;
      end
   end

   assign tx       = tx_reg;
   assign overflow = overflow_reg;
   assign busy     = (state_reg != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_serial_tx_queue.sv
// Directed bench for serial_tx_queue: readiness gating, edge detection,
// overflow, mid-frame reset and frame length (honours SERIAL_TX_PARITY_EN).
module tb_serial_tx_queue;

   localparam int CPB = 100;
`ifdef SERIAL_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       cclk;
   logic [7:0] tx_data;
   logic       new_tx_data;
   logic       tx_block;
   logic       tx;
   logic       busy;
   logic [3:0] fifo_count;
   logic       overflow;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_tx_queue #(
      .CLK_PER_BIT       (CPB),
      .FIFO_DEPTH        (8),
      .CCLK_READY_CYCLES (512)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cclk        (cclk),
      .tx_data     (tx_data),
      .new_tx_data (new_tx_data),
      .tx_block    (tx_block),
      .tx          (tx),
      .busy        (busy),
      .fifo_count  (fifo_count),
      .overflow    (overflow)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: %0h", tag, got);
      end
   endtask

   task automatic pulse(input logic [7:0] d);
      tx_data     = d;
      new_tx_data = 1'b1;
      tick();
      new_tx_data = 1'b0;
      tick();
   endtask

   task automatic wait_start(input int limit, output bit found);
      int n = 0;
      while (tx !== 1'b0 && n < limit) begin
         tick();
         n++;
      end
      found = (tx === 1'b0);
      check("start_seen", 32'(found), 32'd1);
   endtask

   // Entered on the first cycle tx is seen low; samples each bit mid-way.
   task automatic recv_body(input string tag, input logic [7:0] exp, input bit measure);
      logic [7:0] d;
      int elapsed;
      repeat (CPB / 2) tick();
      elapsed = CPB / 2;
      check({tag, "_start"}, 32'(tx), 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) tick();
         elapsed += CPB;
         d[i] = tx;
      end
      check({tag, "_data"}, 32'(d), 32'(exp));
`ifdef SERIAL_TX_PARITY_EN
      repeat (CPB) tick();
      elapsed += CPB;
      check({tag, "_parity"}, 32'(tx), 32'(^exp));
`endif
      repeat (CPB) tick();
      elapsed += CPB;
      check({tag, "_stop"}, 32'(tx), 32'd1);
      if (measure) begin
         check({tag, "_busy_in_stop"}, 32'(busy), 32'd1);
         while (busy === 1'b1 && elapsed < 5000) begin
            tick();
            elapsed++;
         end
         // busy drops with the FSM, one cycle before the registered line finishes stop
         check({tag, "_frame_len"}, 32'(elapsed + 1), 32'(NBITS * CPB));
      end
   endtask

   task automatic recv_frame(input string tag, input logic [7:0] exp, input bit measure);
      bit found;
      wait_start(400, found);
      if (found) recv_body(tag, exp, measure);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lows;
      bit found;
      rst = 1'b1; cclk = 1'b0; tx_data = 8'h00; new_tx_data = 1'b0; tx_block = 1'b0;
      repeat (3) tick();
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;
      tick();

      // cclk ready after 512 cycles, then 0x55 with the 3-cycle start latency
      cclk = 1'b1;
      repeat (512) tick();
      tx_data = 8'h55;
      new_tx_data = 1'b1;
      tick();
      new_tx_data = 1'b0;
      check("lat1_tx", 32'(tx), 32'd1);
      check("lat1_count", 32'(fifo_count), 32'd1);
      tick();
      check("lat2_tx", 32'(tx), 32'd1);
      check("lat2_count", 32'(fifo_count), 32'd0);
      check("lat2_busy", 32'(busy), 32'd1);
      tick();
      check("lat3_tx", 32'(tx), 32'd0);
      recv_body("b55", 8'h55, 1'b1);

      // held-high request queues exactly one byte
      tx_data = 8'hA3;
      new_tx_data = 1'b1;
      recv_frame("bA3", 8'hA3, 1'b1);
      lows = 0;
      repeat (300) begin
         tick();
         if (tx === 1'b0) lows++;
      end
      check("held_extra_lows", 32'(lows), 32'd0);
      check("held_count", 32'(fifo_count), 32'd0);
      check("held_busy", 32'(busy), 32'd0);
      new_tx_data = 1'b0;
      tick();

      // overflow while blocked, then drain in order
      tx_block = 1'b1;
      for (int i = 0; i < 10; i++) pulse(8'(8'h10 + i));
      check("blk_count", 32'(fifo_count), 32'd8);
      check("blk_overflow", 32'(overflow), 32'd1);
      check("blk_tx", 32'(tx), 32'd1);
      tx_block = 1'b0;
      for (int i = 0; i < 8; i++) recv_frame($sformatf("q%0d", i), 8'(8'h10 + i), 1'b0);
      repeat (100) tick();
      check("drain_count", 32'(fifo_count), 32'd0);
      check("drain_overflow", 32'(overflow), 32'd1);

      // cclk low gates transmission; exact readiness edge
      cclk = 1'b0;
      tick();
      pulse(8'h3C);
      pulse(8'hC3);
      lows = 0;
      repeat (600) begin
         tick();
         if (tx === 1'b0) lows++;
      end
      check("cclk0_lows", 32'(lows), 32'd0);
      check("cclk0_count", 32'(fifo_count), 32'd2);
      cclk = 1'b1;
      repeat (511) tick();
      check("rdy511_tx", 32'(tx), 32'd1);
      check("rdy511_count", 32'(fifo_count), 32'd2);
      tick();
      check("rdy512_tx", 32'(tx), 32'd1);
      tick();
      check("rdy513_count", 32'(fifo_count), 32'd1);
      check("rdy513_tx", 32'(tx), 32'd1);
      tick();
      check("rdy514_tx", 32'(tx), 32'd0);
      recv_body("b3C", 8'h3C, 1'b0);
      recv_frame("bC3", 8'hC3, 1'b1);

      // reset mid-DATA with three bytes waiting
      for (int i = 0; i < 4; i++) pulse(8'(8'h81 + i));
      wait_start(400, found);
      repeat (250) tick();
      check("mid_count", 32'(fifo_count), 32'd3);
      check("mid_overflow", 32'(overflow), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_tx", 32'(tx), 32'd1);
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_overflow", 32'(overflow), 32'd0);
      tick();
      rst = 1'b0;
      lows = 0;
      repeat (1200) begin
         tick();
         if (tx === 1'b0) lows++;
      end
      check("post_rst_lows", 32'(lows), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      // frame length and parity on 0x07 (three ones -> parity 1)
      pulse(8'h07);
      recv_frame("b07", 8'h07, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_tx_queue.md
SERIAL_TX_QUEUE -- requirements
Module: serial_tx_queue

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 100, meaning clk cycles per UART bit (50 MHz / 500 kbaud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning byte slots in the queue (power of two, >= 2).
REQ-003 SHALL have parameter CCLK_READY_CYCLES, default 512, meaning consecutive cclk-high cycles before the MCU is deemed ready.
REQ-004 SHALL have port clk, input, 1 bit: the single clock (sys_clock domain); all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port cclk, input, 1 bit: MCU configuration clock/ready indication.
REQ-007 SHALL have port tx_data, input, 8 bits: byte to queue, already synchronized into clk.
REQ-008 SHALL have port new_tx_data, input, 1 bit: level/pulse request, already synchronized; a rising edge queues one byte.
REQ-009 SHALL have port tx_block, input, 1 bit: MCU flow control; high stalls the start of new bytes.
REQ-010 SHALL have port tx, output, 1 bit: UART serial line to the MCU, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is on the line or the queue is non-empty.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current queue occupancy.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag indicating a byte was dropped because the queue was full.

Function
REQ-014 SHALL register new_tx_data once and push tx_data only on the cycle where new_tx_data=1 and its registered value=0; a held-high level SHALL queue exactly one byte.
REQ-015 SHALL push into a FIFO; a push when full SHALL drop the byte, leave contents unchanged, and set overflow.
REQ-016 SHALL, on a simultaneous push and pop, accept both; fifo_count SHALL be unchanged, including when the FIFO is full at that edge.
REQ-017 SHALL keep the cclk_ready counter at 0 while cclk=0; it SHALL increment while cclk=1, saturating at CCLK_READY_CYCLES; ready = (counter == CCLK_READY_CYCLES).
REQ-018 SHALL implement the transmit FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL move IDLE->START when FIFO non-empty, ready=1 and tx_block=0; the pop occurs on that same edge and the byte is latched into a shift register.
REQ-020 SHALL hold START (tx=0), each DATA bit (LSB first, 8 bits) and STOP (tx=1) for exactly CLK_PER_BIT cycles each.
REQ-021 SHALL move STOP->IDLE after its bit time; back-to-back bytes SHALL produce no extra idle bit beyond one IDLE cycle.
REQ-022 SHALL NOT abort an in-flight frame when cclk falls or tx_block rises; stalling applies only at the IDLE decision.
REQ-023 SHALL give a latency of 3 clk cycles from the new_tx_data rising edge (empty FIFO, ready, unblocked) to tx falling for the start bit.
REQ-024 SHALL wrap FIFO pointers modulo FIFO_DEPTH; occupancy SHALL be tracked by count, not by pointer compare.
REQ-025 SHALL drive busy = (state != IDLE) || (fifo_count != 0).

Reset
REQ-026 SHALL, on reset: tx=1, busy=0, fifo_count=0, overflow=0, state=IDLE, cclk counter=0, edge register=0, FIFO pointers=0.
REQ-027 SHALL, when reset is asserted mid-frame, return tx to 1 immediately and discard all queued bytes; overflow SHALL be cleared only by rst.

Configuration
REQ-028 SHALL, with SERIAL_TX_PARITY_EN defined, insert a PARITY state between DATA and STOP driving even parity (XOR of the 8 data bits) for CLK_PER_BIT cycles.
REQ-029 SHALL, without SERIAL_TX_PARITY_EN, omit the PARITY state entirely (DATA->STOP) and produce the frame format 8N1.

Structure
REQ-030 SHALL place the tx state enum, the default CLK_PER_BIT, and the CCLK_READY_CYCLES constant in a shared package used by serial_tx_queue and avr_interface.
REQ-031 SHALL implement the queue as one sub-module, sync_fifo (parameterized width/depth, push/pop/full/empty/count), instantiated once.

Verification
REQ-032 SHALL cover: cclk held high 512 cycles, then a 0x55 pulse -> tx shows start, 1,0,1,0,1,0,1,0, stop, each 100 cycles; busy falls after stop.
REQ-033 SHALL cover: new_tx_data held high 1000 cycles with tx_data=0xA3 -> exactly one 0xA3 frame.
REQ-034 SHALL cover: 10 pulses while tx_block=1 -> fifo_count=8, overflow=1; tx_block released -> first 8 bytes sent in order, then overflow still 1.
REQ-035 SHALL cover: cclk=0 with 2 bytes queued -> tx stays 1; cclk high 511 cycles -> nothing; cycle 512 -> start bit 3 cycles later.
REQ-036 SHALL cover: rst asserted mid-DATA with 3 bytes queued -> tx=1 same cycle, fifo_count=0, no further frames.
REQ-037 SHALL cover: with SERIAL_TX_PARITY_EN, byte 0x07 -> parity bit 1, frame length 11 bit times; without the macro, 10 bit times.
